// File: rtl/data_memory_pkg.sv
// Constants and state encoding shared by the CPU-side memories.
// Word geometry is fixed here so that data and instruction memories decode addresses the same way.
package data_memory_pkg;
    localparam int WORD_WIDTH       = 32;
    localparam int BYTE_OFFSET_BITS = 2;

    typedef enum logic {
        DMEM_INIT  = 1'b0,
        DMEM_READY = 1'b1
    } dmem_state_t;
endpackage

// File: rtl/data_memory_word_ram.sv
// Single-port word RAM with a registered, enable-gated read.
// The read sees the pre-write contents when the read and the write hit the same word.
module word_ram
    import data_memory_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [WORD_WIDTH-1:0] rdata
);
    logic [WORD_WIDTH-1:0] mem [2**ADDR_BITS];

    // The array is kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/data_memory.sv
// Data RAM behind the CPU memory stage: zero-fill sweep after reset, 1-cycle loads,
// and a sticky fault register for misaligned or out-of-range accesses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic                  write_en,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  fault,
    output logic [WORD_WIDTH-1:0] fault_addr
);
    localparam int IDX_LO = BYTE_OFFSET_BITS;
    localparam int IDX_HI = ADDR_BITS + BYTE_OFFSET_BITS - 1;

    dmem_state_t           state, state_next;
    logic [ADDR_BITS-1:0]  clr_ptr, clr_ptr_next;
    logic [ADDR_BITS-1:0]  index;
    logic                  ready, legal, access, rd_ok, wr_ok;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_waddr;
    logic [WORD_WIDTH-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DMEM_INIT;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        if (state == DMEM_INIT) begin
            clr_ptr_next = clr_ptr + 1'b1;
            if (clr_ptr == {ADDR_BITS{1'b1}}) state_next = DMEM_READY;
        end
    end

    assign ready  = (state == DMEM_READY);
    assign busy   = ~ready;
    assign index  = addr[IDX_HI:IDX_LO];
    assign legal  = (addr[IDX_LO-1:0] == '0) && (addr[WORD_WIDTH-1:IDX_HI+1] == '0);
    assign access = read_en | write_en;
    assign rd_ok  = ready & read_en & legal;
    assign wr_ok  = ready & write_en & legal;

    // Sweep owns the write port while busy; CPU stores only land once READY.
    assign ram_we    = ~rst & (busy | wr_ok);
    assign ram_waddr = busy ? clr_ptr : index;
    assign ram_wdata = busy ? '0 : write_data;

    word_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_ok),
        .raddr (index),
        .rdata (read_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            read_valid <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            read_valid <= rd_ok;
            if (ready && access && !legal) begin
                fault <= 1'b1;
                if (!fault) fault_addr <= addr;
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a 16-word array: vector table plus reset/sweep sequences.
module tb_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, write_data = '0;
    logic        read_en = 1'b0, write_en = 1'b0;
    logic [31:0] read_data, fault_addr;
    logic        read_valid, busy, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory #(.ADDR_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .write_data (write_data),
        .read_en    (read_en),
        .write_en   (write_en),
        .read_data  (read_data),
        .read_valid (read_valid),
        .busy       (busy),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [31:0] exp_faddr;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        read_en = rd; write_en = wr; addr = a; write_data = wd;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Counts cycles until busy drops; budget overrun is a failure.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,  1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h14, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h20, 32'h22222222, 1'b1, 32'h11111111, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h3C, 32'h12345678, 1'b0, 32'h22222222, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h3C, 32'h0,        1'b1, 32'h12345678, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h06, 32'hBAD0BAD0, 1'b0, 32'h12345678, 1'b1, 32'h6};
        vecs[10] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 32'h12345678, 1'b1, 32'h6};
        vecs[11] = '{1'b1, 1'b0, 32'h04, 32'h0,        1'b1, 32'h0,        1'b1, 32'h6};
        vecs[12] = '{1'b0, 1'b1, 32'h80000000, 32'h5A5A5A5A, 1'b0, 32'h0,  1'b1, 32'h6};
        vecs[13] = '{1'b1, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0,        1'b1, 32'h6};

        // Reset state
        cycle();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(read_valid), 32'd0);
        chk("rst_data", read_data, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_faddr", fault_addr, 32'h0);

        // Sweep with ignored requests: stores to 0x08, then an illegal read
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h08, 32'hAAAA5555);
        n = 0; bad = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
            if (read_valid !== 1'b0 || fault !== 1'b0) bad++;
            if (n == 3) drive(1'b1, 1'b0, 32'h06, 32'h0);
            if (n == 5) drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sweep_len", n, 16);
        chk("sweep_quiet", bad, 0);

        // Every word reads 0, valid one cycle after the request
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
            cycle();
            if (read_valid !== 1'b1 || read_data !== 32'h0) bad++;
        end
        chk("zero_reads", bad, 0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("idle_valid", 32'(read_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
            cycle();
            chk($sformatf("v%0d_valid", i), 32'(read_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_data", i), read_data, vecs[i].exp_data);
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
            chk($sformatf("v%0d_faddr", i), fault_addr, vecs[i].exp_faddr);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset clears the fault; then reset again mid-sweep
        rst = 1'b1;
        cycle();
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_faddr", fault_addr, 32'h0);
        chk("rst2_data", read_data, 32'h0);
        chk("rst2_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        repeat (7) cycle();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_busy(n);
        chk("mid_sweep_len", n, 16);

        drive(1'b1, 1'b0, 32'h3C, 32'h0);
        cycle();
        chk("post_3c_valid", 32'(read_valid), 32'd1);
        chk("post_3c_data", read_data, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        cycle();
        chk("post_10_data", read_data, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("post_idle_valid", 32'(read_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
